// File: rtl/port_fifo_pkg.sv
// Shared constants and types for the port-mapped byte FIFO.
package port_fifo_pkg;

  localparam int DEFAULT_DEPTH_LOG2  = 4;
  localparam int DEFAULT_SYNC_STAGES = 2;

  typedef logic [7:0] BYTE_T;

endpackage

// File: rtl/port_fifo_strobe_sync.sv
// Synchroniser, armed flag and one-cycle completion event for an active-low
// asynchronous strobe, with an optional matching data pipeline.
module strobe_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int DW          = 8,
  parameter bit HAS_DATA    = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          strobe_n,
  input  logic [DW-1:0] data_in,
  output logic          event_o,
  output logic [DW-1:0] data_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES-1:0] live_q, live_d;
  logic                   prev_q, prev_d;
  logic                   prev_live_q, prev_live_d;
  logic                   armed_q, armed_d;
  logic                   sync_s;

  assign sync_s = sync_q[SYNC_STAGES-1];

  // live_q marks stages holding real pin samples rather than reset fill, so a
  // strobe already low at reset release never looks like a fresh falling edge.
  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], strobe_n};
    live_d      = {live_q[SYNC_STAGES-2:0], 1'b1};
    prev_d      = sync_s;
    prev_live_d = live_q[SYNC_STAGES-1];
    armed_d     = armed_q;
    event_o     = 1'b0;
    if (!sync_s && prev_q && prev_live_q) begin
      armed_d = 1'b1;
    end else if (sync_s && !prev_q && armed_q) begin
      event_o = 1'b1;
      armed_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q      <= '1;
      live_q      <= '0;
      prev_q      <= 1'b1;
      prev_live_q <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      live_q      <= live_d;
      prev_q      <= prev_d;
      prev_live_q <= prev_live_d;
      armed_q     <= armed_d;
    end
  end

  generate
    if (HAS_DATA) begin : g_data
      logic [DW-1:0] pipe_q [SYNC_STAGES];
      logic [DW-1:0] pipe_d [SYNC_STAGES];
      logic [DW-1:0] held_q, held_d;

      always_comb begin
        pipe_d[0] = data_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
          pipe_d[i] = pipe_q[i-1];
        end
        // Keep the bus value seen on the last cycle the strobe was still low.
        held_d = sync_s ? held_q : pipe_q[SYNC_STAGES-1];
      end

      for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
        always_ff @(posedge clk) begin
          if (reset) pipe_q[gi] <= '0;
          else       pipe_q[gi] <= pipe_d[gi];
        end
      end

      always_ff @(posedge clk) begin
        if (reset) held_q <= '0;
        else       held_q <= held_d;
      end

      assign data_o = held_q;
    end else begin : g_no_data
      logic data_in_unused;
      assign data_in_unused = ^data_in;
      assign data_o         = '0;
    end
  endgenerate

endmodule

// File: rtl/port_fifo.sv
// Port-mapped 8-bit FIFO driven by asynchronous active-low write/read strobes.
// Optional sticky overflow/underflow flags: define PORT_FIFO_ERR_FLAGS_EN.
module port_fifo
  import port_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2  = DEFAULT_DEPTH_LOG2,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        data_in,
  input  logic              _wr,
  input  logic              _rd,
  output logic [7:0]        data_out,
  output logic              data_oe,
  output logic              empty,
  output logic              full,
  output logic [DEPTH_LOG2:0] count
`ifdef PORT_FIFO_ERR_FLAGS_EN
  ,
  input  logic              clear_err,
  output logic              overflow,
  output logic              underflow
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

  BYTE_T                 mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  wr_event, rd_event;
  logic                  do_push, do_pop;
  BYTE_T                 wr_byte;
  logic                  rd_data_unused;

  strobe_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .DW          (8),
    .HAS_DATA    (1'b1)
  ) u_wr_sync (
    .clk      (clk),
    .reset    (reset),
    .strobe_n (_wr),
    .data_in  (data_in),
    .event_o  (wr_event),
    .data_o   (wr_byte)
  );

  strobe_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .DW          (1),
    .HAS_DATA    (1'b0)
  ) u_rd_sync (
    .clk      (clk),
    .reset    (reset),
    .strobe_n (_rd),
    .data_in  (1'b0),
    .event_o  (rd_event),
    .data_o   (rd_data_unused)
  );

  // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
  always_comb begin
    do_pop   = rd_event && (count_q != '0);
    do_push  = wr_event && ((count_q != FULL_COUNT) || do_pop);
    wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(do_push);
    rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(do_pop);
    count_d  = count_q + (DEPTH_LOG2 + 1)'(do_push) - (DEPTH_LOG2 + 1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wr_byte;
  end

  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_COUNT);
  assign count    = count_q;
  assign data_oe  = !_rd;
  assign data_out = empty ? 8'h00 : mem[rd_ptr_q];

`ifdef PORT_FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // A new error in the clear cycle takes priority so it is never lost.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clear_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (wr_event && !do_push) overflow_d  = 1'b1;
    if (rd_event && !do_pop)  underflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule
